// File: rtl/nor3_sweep_ctrl.sv
// ==========================================================================
// nor3_sweep_ctrl : clocked 8-vector sweep of a 3-input gate with checking
// Optional macro NOR3_SWEEP_SYNC_EN adds a 2-flop d_in synchronizer. Rev 1.0
// ==========================================================================
`default_nettype none

module nor3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECT        = 8'b0000_0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       d_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_vec,
    output logic [7:0] captured
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    logic d_smp;

`ifdef NOR3_SWEEP_SYNC_EN
    // Two extra settle cycles cover the synchronizer latency.
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES + 2;
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], d_in};
    end
    assign d_smp = sync_q[1];
`else
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES;
    assign d_smp = d_in;
`endif

    localparam logic [8:0] CNT_LAST = 9'(SETTLE_LEN - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] fail_q, fail_d;
    logic       pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 9'd0;
            abc_q   <= 3'd0;
            cap_q   <= 8'd0;
            fail_q  <= 8'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            cap_q   <= cap_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        cap_d   = cap_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = APPLY;
                    idx_d   = 3'd0;
                    abc_d   = 3'd0;
                    cap_d   = 8'd0;
                    fail_d  = 8'd0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                state_d = SETTLE;
                cnt_d   = 9'd0;
            end
            SETTLE: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == CNT_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                cap_d[idx_q]  = d_smp;
                fail_d[idx_q] = d_smp ^ EXPECT[idx_q];
                if (idx_q != 3'd7) begin
                    idx_d   = idx_q + 3'd1;
                    abc_d   = idx_q + 3'd1;
                    state_d = APPLY;
                end else begin
                    // fail_d already includes this final vector's bit.
                    pass_d  = ~|fail_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                abc_d   = 3'd0;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything above, including a same-edge capture.
        if (abort && (state_q == APPLY || state_q == SETTLE || state_q == SAMPLE)) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            cnt_d   = 9'd0;
            abc_d   = 3'd0;
            cap_d   = 8'd0;
            fail_d  = 8'd0;
            pass_d  = 1'b0;
        end
    end

    assign a_out    = abc_q[2];
    assign b_out    = abc_q[1];
    assign c_out    = abc_q[0];
    assign busy     = (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign fail_vec = fail_q;
    assign captured = cap_q;

endmodule

`default_nettype wire
